ov7670_frame_tx: RTL

OV7670_FRAME_TX -- requirements
Module: ov7670_frame_tx

---
 rtl/ov7670_pkg.sv | 30 +++
 rtl/ov7670_pattern_gen.sv | 22 ++
 rtl/ov7670_frame_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670-format frame transmitter.
// No logic: states, pattern source encodings and RGB444 byte packing.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PAT_EXT   = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_RED   = 2'd3
    } pattern_e;

    localparam logic [3:0]  BYTE0_PAD = 4'h0;
    localparam logic [11:0] PIX_WHITE = 12'hFFF;
    localparam logic [11:0] PIX_BLACK = 12'h000;
    localparam logic [11:0] PIX_RED   = 12'hF00;

    // First byte carries red in the low nibble, second byte carries {G,B}.
    function automatic logic [7:0] pack_byte(input logic [11:0] pix, input logic first);
        return first ? {BYTE0_PAD, pix[11:8]} : pix[7:0];
    endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational test-pattern source: (x, y, sel) -> RGB444 pixel.
// Zero latency, no flow control; returns black when the external source is selected.
module ov7670_pattern_gen
    import ov7670_pkg::*;
(
    input  logic [7:0]  i_x,
    input  logic [3:0]  i_y,
    input  pattern_e    i_sel,
    output logic [11:0] o_pixel
);

    always_comb begin
        o_pixel = PIX_BLACK;
        case (i_sel)
            PAT_RAMP:  o_pixel = {i_y, i_x};
            PAT_CHECK: o_pixel = (i_x[3] ^ i_y[3]) ? PIX_WHITE : PIX_BLACK;
            PAT_RED:   o_pixel = PIX_RED;
            default:   o_pixel = PIX_BLACK;
        endcase
    end

endmodule

// File: rtl/ov7670_frame_tx.sv
// OV7670-style vsync/href/byte stream generator with internal patterns or an external pixel source.
// Outputs registered and aligned with the FSM state; source is paced by a one-cycle pixel_req lookahead.
module ov7670_frame_tx
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] ext_pixel,
    output logic        pixel_req,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done,
    output logic        busy
);

    localparam int L         = 2 * H_ACTIVE + H_BLANK;
    localparam int MAX_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LCW       = (L > 1) ? $clog2(L) : 1;
    localparam int LNW       = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    localparam logic [LCW-1:0] LC_LAST       = LCW'(L - 1);
    localparam logic [LCW:0]   LC_HREF_END   = (LCW+1)'(2 * H_ACTIVE);
    localparam logic [LCW:0]   LC_REQ_END    = (LCW+1)'(2 * H_ACTIVE - 1);
    localparam logic [LNW-1:0] LN_ACT_LAST   = LNW'(V_ACTIVE - 1);
    localparam logic [LNW-1:0] LN_BACK_LAST  = LNW'(V_BACK - 1);
    localparam logic [LNW-1:0] LN_FRONT_LAST = LNW'(V_FRONT - 1);

    state_e         r_state, w_state_nx;
    logic [LCW-1:0] r_lc, w_lc_nx;
    logic [LNW-1:0] r_line, w_ln_nx, w_ln_last;
    pattern_e       r_sel, w_sel_nx;
    logic [11:0]    r_hold;

    logic           w_href_nx, w_first_nx, w_req_nx, w_done_nx;
    logic [7:0]     w_gx;
    logic [3:0]     w_gy;
    logic [11:0]    w_gen_pix, w_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_lc    <= '0;
            r_line  <= '0;
            r_sel   <= PAT_EXT;
        end else begin
            r_state <= w_state_nx;
            r_lc    <= w_lc_nx;
            r_line  <= w_ln_nx;
            r_sel   <= w_sel_nx;
        end
    end

    always_comb begin
        w_ln_last = '0;
        case (r_state)
            ST_VSYNC:  w_ln_last = LNW'(VSYNC_LINES - 1);
            ST_VBACK:  w_ln_last = LN_BACK_LAST;
            ST_ACTIVE: w_ln_last = LN_ACT_LAST;
            ST_VFRONT: w_ln_last = LN_FRONT_LAST;
            default:   w_ln_last = '0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_lc_nx    = r_lc;
        w_ln_nx    = r_line;
        w_sel_nx   = r_sel;
        if (r_state == ST_IDLE) begin
            w_lc_nx = '0;
            w_ln_nx = '0;
            if (enable) begin
                w_state_nx = ST_VSYNC;
                w_sel_nx   = pattern_e'(pattern_sel);
            end
        end else if (r_lc == LC_LAST) begin
            w_lc_nx = '0;
            if (r_line == w_ln_last) begin
                w_ln_nx = '0;
                case (r_state)
                    ST_VSYNC:  w_state_nx = ST_VBACK;
                    ST_VBACK:  w_state_nx = ST_ACTIVE;
                    ST_ACTIVE: w_state_nx = ST_VFRONT;
                    default: begin
                        // Enable is only consulted at frame boundaries, so frames never truncate.
                        if (enable) begin
                            w_state_nx = ST_VSYNC;
                            w_sel_nx   = pattern_e'(pattern_sel);
                        end else begin
                            w_state_nx = ST_IDLE;
                        end
                    end
                endcase
            end else begin
                w_ln_nx = r_line + 1'b1;
            end
        end else begin
            w_lc_nx = r_lc + 1'b1;
        end
    end

    // Output registers are loaded from the next-state view so they line up with the state.
    assign w_href_nx  = (w_state_nx == ST_ACTIVE) && ({1'b0, w_lc_nx} < LC_HREF_END);
    assign w_first_nx = ~w_lc_nx[0];
    assign w_gx       = 8'(w_lc_nx >> 1);
    assign w_gy       = 4'(w_ln_nx);
    assign w_req_nx   = (w_sel_nx == PAT_EXT) &&
                        (((w_state_nx == ST_ACTIVE) && w_lc_nx[0] && ({1'b0, w_lc_nx} < LC_REQ_END)) ||
                         ((w_lc_nx == LC_LAST) &&
                          (((w_state_nx == ST_ACTIVE) && (w_ln_nx != LN_ACT_LAST)) ||
                           ((w_state_nx == ST_VBACK) && (w_ln_nx == LN_BACK_LAST)))));
    assign w_done_nx  = (w_state_nx == ST_VFRONT) && (w_lc_nx == LC_LAST) && (w_ln_nx == LN_FRONT_LAST);
    assign w_pix      = (w_sel_nx == PAT_EXT) ? (w_first_nx ? ext_pixel : r_hold) : w_gen_pix;

    ov7670_pattern_gen u_pattern_gen (
        .i_x     (w_gx),
        .i_y     (w_gy),
        .i_sel   (w_sel_nx),
        .o_pixel (w_gen_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            d          <= 8'h00;
            pixel_req  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            r_hold     <= '0;
        end else begin
            vsync      <= (w_state_nx == ST_VSYNC);
            busy       <= (w_state_nx != ST_IDLE);
            href       <= w_href_nx;
            d          <= w_href_nx ? pack_byte(w_pix, w_first_nx) : 8'h00;
            pixel_req  <= w_req_nx;
            frame_done <= w_done_nx;
            if (w_href_nx && w_first_nx) begin
                r_hold <= ext_pixel;
            end
        end
    end

endmodule
